fram_word_arbiter: RTL and testbench

- Shares the single byte-wide SPI FRAM engine between two 32-bit requesters: instruction fetch (read-only) and data (read/write with byte enables).
- Each granted word access is split into up to four sequential byte transactions on the engine.
- The block sequences those transactions, assembles or scatters the bytes little-endian, and returns one ack per word.
- Sits between the core's memory ports and the SPI engine.

---
 rtl/fram_pkg.sv | 27 ++
 rtl/fram_rr_arb2.sv | 34 +++
 rtl/fram_word_arbiter.sv | 138 +++++++++++++
 tb/tb_fram_word_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fram_pkg.sv
// rtl/fram_pkg.sv - shared types and helpers for the FRAM word arbiter
package fram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    localparam int   BYTES_PER_WORD = 4;

    // Lowest enabled byte index at or above 'from'; bit 2 set means none left.
    function automatic logic [2:0] next_byte(input logic [3:0] en, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b100;
        for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
            if (en[i] && (3'(i) >= from)) begin
                r = {1'b0, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fram_rr_arb2.sv
// rtl/fram_rr_arb2.sv - two-input round-robin arbiter, fetch vs data
import fram_pkg::*;

module fram_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_fetch,
    input  logic req_data,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_port
);

    logic last_grant;

    always_comb begin
        grant_valid = req_fetch | req_data;
        if (req_fetch && req_data) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = req_data ? PORT_DATA : PORT_FETCH;
        end
    end

    // Resetting to DATA hands the very first tie to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_DATA;
        end else if (grant_en && grant_valid) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/fram_word_arbiter.sv
// rtl/fram_word_arbiter.sv - splits 32-bit fetch/data accesses into SPI FRAM byte transactions
import fram_pkg::*;

module fram_word_arbiter #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_be,
    output logic [31:0]           d_rdata,
    output logic                  d_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_busy,
    input  logic                  mem_done
);

    state_t                state, state_nxt;
    logic [1:0]            k;
    logic                  port_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_q;
    logic [3:0]            be_q;

    logic                  grant_en;
    logic                  grant_valid;
    logic                  grant_port;
    logic                  grant_we;
    logic [3:0]            grant_be;
    logic [2:0]            first_sel;
    logic [2:0]            next_sel;
    logic [3:0]            en_cur;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    assign grant_en = (state == ST_IDLE);

    fram_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_fetch   (i_req),
        .req_data    (d_req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Reads always move all four bytes; only writes honour the byte enables.
    assign grant_we  = (grant_port == PORT_DATA) && d_we;
    assign grant_be  = grant_we ? d_be : 4'hF;
    assign first_sel = next_byte(grant_be, 3'd0);
    assign en_cur    = we_q ? be_q : 4'hF;
    assign next_sel  = next_byte(en_cur, {1'b0, k} + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_valid) state_nxt = first_sel[2] ? ST_ACK : ST_ISSUE;
            ST_ISSUE: if (!mem_busy) state_nxt = ST_WAIT;
            ST_WAIT:  if (mem_done) state_nxt = next_sel[2] ? ST_ACK : ST_ISSUE;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = base_q + {{(ADDR_WIDTH-2){1'b0}}, k};
        mem_wdata = wdata_q[{k, 3'b000} +: 8];
        mem_re    = (state == ST_ISSUE) && !mem_busy && !we_q;
        mem_we    = (state == ST_ISSUE) && !mem_busy && we_q;
        i_ack     = (state == ST_ACK) && (port_q == PORT_FETCH);
        d_ack     = (state == ST_ACK) && (port_q == PORT_DATA);
    end

    assign i_rdata = word_q;
    assign d_rdata = word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= 2'd0;
            port_q  <= PORT_FETCH;
            we_q    <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'h0;
            word_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        port_q  <= grant_port;
                        base_q  <= {(grant_port == PORT_DATA) ? d_addr[ADDR_WIDTH-1:2]
                                                              : i_addr[ADDR_WIDTH-1:2], 2'b00};
                        we_q    <= grant_we;
                        wdata_q <= (grant_port == PORT_DATA) ? d_wdata : 32'h0;
                        be_q    <= grant_be;
                        k       <= first_sel[1:0];
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        if (!we_q) begin
                            word_q[{k, 3'b000} +: 8] <= mem_rdata;
                        end
                        if (!next_sel[2]) begin
                            k <= next_sel[1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fram_word_arbiter.sv
// tb/tb_fram_word_arbiter.sv - directed bench for fram_word_arbiter with a byte-engine model
module tb_fram_word_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_busy;
    logic        mem_done;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } xact_t;

    xact_t      log_q[$];
    logic [7:0] fmem [0:65535];
    int         total = 0;
    int         bad = 0;
    int         t_eng = 1;
    int         i_acks = 0;
    int         d_acks = 0;

    fram_word_arbiter #(.ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Engine model: strobe seen at a negedge, done pulses t_eng cycles later.
    initial begin
        int          cnt;
        logic [15:0] p_addr;
        logic        p_we;
        logic [7:0]  p_wd;
        cnt = 0; p_addr = '0; p_we = 1'b0; p_wd = '0;
        mem_done = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_done = 1'b1;
                        mem_rdata = fmem[p_addr];
                        if (p_we) fmem[p_addr] = p_wd;
                    end
                end
                if (mem_re || mem_we) begin
                    if (mem_re && mem_we) begin
                        total++; bad++;
                        $display("FAIL strobe_excl: re=%b we=%b, want not both", mem_re, mem_we);
                    end
                    log_q.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
                    p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
                    cnt = t_eng;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (i_ack) i_acks++;
            if (d_ack) d_acks++;
        end
    end

    task automatic wait_ack(input bit fetch, output int n);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n++;
            if (fetch ? i_ack : d_ack) return;
        end
        total++; bad++;
        $display("FAIL ack_timeout: no ack after %0d cycles, want one", n);
    endtask

    task automatic run_fetch(input logic [15:0] a, output int n);
        @(negedge clk);
        i_addr = a;
        i_req = 1'b1;
        wait_ack(1'b1, n);
        i_req = 1'b0;
    endtask

    task automatic run_data(input logic we, input logic [15:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output int n);
        @(negedge clk);
        d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        d_req = 1'b1;
        wait_ack(1'b0, n);
        d_req = 1'b0;
    endtask

    initial begin
        int          n;
        int          a0;
        logic [31:0] exp_w;
        bit          got_q[$];

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_busy = 1'b0;
        fmem[16'h0100] = 8'h11; fmem[16'h0101] = 8'h22;
        fmem[16'h0102] = 8'h33; fmem[16'h0103] = 8'h44;
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({i_ack, d_ack, mem_re, mem_we}), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_rdata", i_rdata | d_rdata, 32'h0);
        rst_n = 1'b1;

        // Simultaneous requests from reset, held: F,D,F,D
        @(negedge clk);
        i_addr = 16'h0100; d_addr = 16'h0100; d_we = 1'b0; d_be = 4'h0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                got_q.push_back(d_ack);
                if (got_q.size() == 4) break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_count", 32'(got_q.size()), 32'd4);
        for (int j = 0; j < 4 && j < got_q.size(); j++)
            check($sformatf("rr_order%0d", j), 32'(got_q[j]), 32'(j % 2));
        check("rr_rdata", d_rdata, 32'h44332211);

        // Fetch with unaligned address
        log_q.delete();
        a0 = i_acks;
        run_fetch(16'h0102, n);
        check("fetch_lat", 32'(n), 32'd9);
        check("fetch_rdata", i_rdata, 32'h44332211);
        @(negedge clk);
        check("fetch_acks", 32'(i_acks - a0), 32'd1);
        check("fetch_nbytes", 32'(log_q.size()), 32'd4);
        for (int j = 0; j < 4 && j < log_q.size(); j++)
            check($sformatf("fetch_b%0d", j), 32'({log_q[j].we, log_q[j].addr}), 32'({1'b0, 16'h0100 + 16'(j)}));

        // Sparse write, be=1010
        log_q.delete();
        a0 = d_acks;
        run_data(1'b1, 16'h0200, 32'hAABBCCDD, 4'b1010, n);
        check("wr_lat", 32'(n), 32'd5);
        check("wr_keeps_word", d_rdata, 32'h44332211);
        @(negedge clk);
        check("wr_acks", 32'(d_acks - a0), 32'd1);
        check("wr_nbytes", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("wr_b0", 32'({log_q[0].we, log_q[0].addr, log_q[0].data}), 32'({1'b1, 16'h0201, 8'hCC}));
            check("wr_b1", 32'({log_q[1].we, log_q[1].addr, log_q[1].data}), 32'({1'b1, 16'h0203, 8'hAA}));
        end

        // Write with no byte enables
        log_q.delete();
        run_data(1'b1, 16'h0200, 32'h0, 4'b0000, n);
        check("be0_lat", 32'(n), 32'd1);
        @(negedge clk);
        check("be0_nbytes", 32'(log_q.size()), 32'd0);

        // Engine busy for 5 cycles in ISSUE
        log_q.delete();
        mem_busy = 1'b1;
        @(negedge clk);
        i_addr = 16'h0100;
        i_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("busy_nostrobe%0d", j), 32'({mem_re, mem_we}), 32'h0);
            check($sformatf("busy_addr%0d", j), 32'(mem_addr), 32'h0100);
        end
        @(posedge clk);
        #1 mem_busy = 1'b0;
        @(negedge clk);
        check("busy_strobe", 32'({mem_re, mem_we}), 32'b10);
        check("busy_addr_rel", 32'(mem_addr), 32'h0100);
        wait_ack(1'b1, n);
        i_req = 1'b0;
        check("busy_rdata", i_rdata, 32'h44332211);

        // Inputs changed after grant must not affect the word
        log_q.delete();
        exp_w = 32'h12345678;
        @(negedge clk);
        d_we = 1'b1; d_addr = 16'h0300; d_wdata = exp_w; d_be = 4'hF;
        d_req = 1'b1;
        @(negedge clk);
        d_addr = 16'h0400; d_wdata = 32'h0; d_be = 4'h0; d_we = 1'b0;
        wait_ack(1'b0, n);
        d_req = 1'b0;
        check("latch_nbytes", 32'(log_q.size()), 32'd4);
        for (int j = 0; j < 4 && j < log_q.size(); j++)
            check($sformatf("latch_b%0d", j), 32'({log_q[j].we, log_q[j].addr, log_q[j].data}),
                  32'({1'b1, 16'h0300 + 16'(j), exp_w[8*j +: 8]}));
        run_data(1'b0, 16'h0302, 32'h0, 4'h0, n);
        check("rd_back_lat", 32'(n), 32'd9);
        check("rd_back", d_rdata, exp_w);

        // Reset while waiting on byte 2
        t_eng = 3;
        log_q.delete();
        @(negedge clk);
        i_addr = 16'h0100;
        i_req = 1'b1;
        for (int c = 0; c < 100 && log_q.size() < 3; c++) @(negedge clk);
        check("mid_reached_b2", 32'(log_q.size()), 32'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", 32'({i_ack, d_ack, mem_re, mem_we}), 32'h0);
        check("mid_rst_addr", 32'({mem_addr, mem_wdata}), 32'h0);
        check("mid_rst_rdata", i_rdata | d_rdata, 32'h0);
        i_req = 1'b0;
        a0 = i_acks;
        repeat (3) @(negedge clk);
        check("mid_rst_noack", 32'(i_acks - a0), 32'd0);
        rst_n = 1'b1;
        t_eng = 1;
        run_fetch(16'h0100, n);
        check("post_rst_lat", 32'(n), 32'd9);
        check("post_rst_rdata", i_rdata, 32'h44332211);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
